// File: rtl/hamming_stream_encoder.sv
// Streaming Hamming SEC encoder with a 2-entry output FIFO and delivered-word counter.
// Define HAMMING_SECDED_EN to append an overall even-parity bit (SECDED codeword).
module hamming_stream_encoder #(
  parameter int DATA_W = 7,
  parameter int CNT_W  = 16,
  localparam int PAR_W = (DATA_W <= 1)  ? 2 :
                         (DATA_W <= 4)  ? 3 :
                         (DATA_W <= 11) ? 4 :
                         (DATA_W <= 26) ? 5 :
                         (DATA_W <= 57) ? 6 : 7,
  localparam int HAM_W = DATA_W + PAR_W,
`ifdef HAMMING_SECDED_EN
  localparam int CODE_W = HAM_W + 1
`else
  localparam int CODE_W = HAM_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W:1]   data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W:1]   encoded,
  output logic [CNT_W-1:0]  word_count
);

  function automatic logic [CODE_W:1] encode(input logic [DATA_W:1] d);
    logic [CODE_W:1] cw;
    int unsigned     di;
    logic            p;
    cw = '0;
    di = 1;
    for (int unsigned pos = 1; pos <= HAM_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[di];
        di++;
      end
    end
    // Parity at 2^k covers every data position whose index has bit k set.
    for (int unsigned k = 0; k < PAR_W; k++) begin
      p = 1'b0;
      for (int unsigned pos = 3; pos <= HAM_W; pos++) begin
        if (((pos & (pos - 1)) != 0) && (((pos >> k) & 1) != 0))
          p = p ^ cw[pos];
      end
      cw[1 << k] = p;
    end
`ifdef HAMMING_SECDED_EN
    cw[CODE_W] = ^cw[HAM_W:1];
`endif
    return cw;
  endfunction

  logic [CODE_W:1]  slot [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [CNT_W-1:0] wc;
  logic             push;
  logic             pop;

  assign in_ready   = !rst && (count != 2'd2);
  assign out_valid  = (count != 2'd0);
  assign encoded    = slot[rd_ptr];
  assign word_count = wc;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot[0] <= '0;
      slot[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      wc      <= '0;
    end else begin
      if (push) begin
        slot[wr_ptr] <= encode(data);
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        wc     <= wc + 1'b1;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_hamming_stream_encoder.sv
// Scoreboard bench: five encoder instances (DATA_W 7/1/4/26/57) share one stimulus stream
// and are checked against a syndrome-based reference model.
module tb_hamming_stream_encoder;

`ifdef HAMMING_SECDED_EN
  localparam int SEC = 1;
`else
  localparam int SEC = 0;
`endif
  localparam int NDUT = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [57:1] din;
  logic [4:0]  ir;
  logic [4:0]  ov;
  logic [11+SEC:1] enc7;
  logic [3+SEC:1]  enc1;
  logic [7+SEC:1]  enc4;
  logic [31+SEC:1] enc26;
  logic [63+SEC:1] enc57;
  logic [3:0]  wc7;
  logic [15:0] wc1, wc4, wc26, wc57;

  int checks = 0;
  int errors = 0;
  int exp_wc = 0;
  int dir_on = 0;
  int dir_idx = 0;
  logic [63:0] sbq[$];

  always #5 clk = ~clk;

  hamming_stream_encoder #(.DATA_W(7), .CNT_W(4)) dut7 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .data(din[7:1]),
    .out_valid(ov[0]), .out_ready(out_ready), .encoded(enc7), .word_count(wc7));
  hamming_stream_encoder #(.DATA_W(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .data(din[1:1]),
    .out_valid(ov[1]), .out_ready(out_ready), .encoded(enc1), .word_count(wc1));
  hamming_stream_encoder #(.DATA_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .data(din[4:1]),
    .out_valid(ov[2]), .out_ready(out_ready), .encoded(enc4), .word_count(wc4));
  hamming_stream_encoder #(.DATA_W(26)) dut26 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .data(din[26:1]),
    .out_valid(ov[3]), .out_ready(out_ready), .encoded(enc26), .word_count(wc26));
  hamming_stream_encoder #(.DATA_W(57)) dut57 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[4]), .data(din),
    .out_valid(ov[4]), .out_ready(out_ready), .encoded(enc57), .word_count(wc57));

  function automatic int dw_of(input int i);
    case (i)
      0: return 7;
      1: return 1;
      2: return 4;
      3: return 26;
      default: return 57;
    endcase
  endfunction

  function automatic logic [63:0] get_enc(input int i);
    case (i)
      0: return 64'(enc7);
      1: return 64'(enc1);
      2: return 64'(enc4);
      3: return 64'(enc26);
      default: return 64'(enc57);
    endcase
  endfunction

  function automatic logic [63:0] get_wc(input int i);
    case (i)
      0: return 64'(wc7);
      1: return 64'(wc1);
      2: return 64'(wc4);
      3: return 64'(wc26);
      default: return 64'(wc57);
    endcase
  endfunction

  function automatic int ham_of(input int dw);
    int p = 0;
    while ((1 << p) < dw + p + 1) p++;
    return dw + p;
  endfunction

  // Reference: data fills non-power-of-two positions; the parity bits are the
  // binary digits of the XOR of indices of all set data positions.
  function automatic logic [63:0] ref_encode(input logic [63:0] d, input int dw);
    logic [63:0] code = '0;
    int ham = ham_of(dw);
    int j = 0;
    int s = 0;
    for (int pos = 1; pos <= ham; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        code[pos-1] = d[j];
        if (d[j]) s = s ^ pos;
        j++;
      end
    end
    for (int k = 0; (1 << k) <= ham; k++)
      code[(1 << k) - 1] = ((s >> k) & 1) != 0;
    if (SEC == 1) code[ham] = ^code;
    return code;
  endfunction

  function automatic logic [63:0] syndrome(input logic [63:0] code, input int dw);
    int ham = ham_of(dw);
    int s = 0;
    for (int pos = 1; pos <= ham; pos++)
      if (code[pos-1]) s = s ^ pos;
    if (SEC == 1 && (^code) != 1'b0) s = s | 'h100;
    return 64'(s);
  endfunction

  function automatic logic [63:0] dir_const(input int i);
    if (SEC == 1) begin
      case (i)
        0: return 64'h807;
        1: return 64'hFFF;
        default: return 64'h483;
      endcase
    end
    case (i)
      0: return 64'h007;
      1: return 64'h7FF;
      default: return 64'h483;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Monitor: outputs are sampled on the negedge, half a cycle before the edge that acts on them.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      exp_wc = 0;
    end else begin
      for (int i = 1; i < NDUT; i++) begin
        chk($sformatf("in_ready_eq%0d", dw_of(i)), 64'(ir[i]), 64'(ir[0]));
        chk($sformatf("out_valid_eq%0d", dw_of(i)), 64'(ov[i]), 64'(ov[0]));
      end
      chk("word_count7", get_wc(0), 64'(exp_wc % 16));
      for (int i = 1; i < NDUT; i++)
        chk($sformatf("word_count%0d", dw_of(i)), get_wc(i), 64'(exp_wc % 65536));
      if (ov[0]) begin
        for (int i = 0; i < NDUT; i++)
          chk($sformatf("syndrome%0d", dw_of(i)), syndrome(get_enc(i), dw_of(i)), 64'd0);
      end
      if (ov[0] && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output", 64'(ov[0]), 64'd0);
        end else begin
          logic [63:0] d;
          d = sbq.pop_front();
          for (int i = 0; i < NDUT; i++)
            chk($sformatf("code%0d", dw_of(i)), get_enc(i), ref_encode(d, dw_of(i)));
          if (dir_on != 0 && dir_idx < 3) begin
            chk("dir_const", get_enc(0), dir_const(dir_idx));
            dir_idx++;
          end
        end
        exp_wc++;
      end
      if (in_valid && ir[0]) sbq.push_back({7'b0, din});
    end
  end

  initial begin
    #600000;
    $display("FAIL timeout t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(ir[0]), 64'd0);
    chk("rst_out_valid", 64'(ov[0]), 64'd0);
    chk("rst_encoded", get_enc(0), 64'd0);
    chk("rst_word_count", get_wc(0), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(ir[0]), 64'd1);

    // Directed back-to-back words with the sink always ready.
    out_ready = 1'b1;
    dir_on = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      din = (i == 0) ? 57'h01 : (i == 1) ? 57'h7F : 57'h40;
      @(posedge clk); #1;
      if (i == 0) chk("latency_out_valid", 64'(ov[0]), 64'd1);
    end
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("dir_count", 64'(dir_idx), 64'd3);
    chk("dir_word_count16", get_wc(3), 64'd3);
    dir_on = 0;

    // Back-pressure: only two words fit; head must stay put.
    out_ready = 1'b0;
    in_valid = 1'b1;
    din = 57'h01;
    @(posedge clk); #1;
    din = 57'h02;
    @(posedge clk); #1;
    chk("bp_in_ready_full", 64'(ir[0]), 64'd0);
    din = 57'h03;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_in_ready_hold", 64'(ir[0]), 64'd0);
      chk("bp_head_stable", get_enc(0), dir_const(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after_pop", 64'(ir[0]), 64'd1);
    repeat (2) begin @(posedge clk); #1; end
    chk("bp_drained", 64'(ov[0]), 64'd0);

    // Reset with two words buffered; they must never emerge.
    out_ready = 1'b0;
    in_valid = 1'b1;
    din = 57'h15;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("rst_in_ready_low", 64'(ir[0]), 64'd0);
    @(posedge clk); #1;
    chk("mid_rst_out_valid", 64'(ov[0]), 64'd0);
    chk("mid_rst_encoded", get_enc(0), 64'd0);
    chk("mid_rst_word_count", get_wc(0), 64'd0);
    chk("mid_rst_in_ready", 64'(ir[0]), 64'd0);
    @(posedge clk); #1;
    chk("rst_ignores_valid", 64'(ov[0]), 64'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rel_in_ready", 64'(ir[0]), 64'd1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_ghost_word", 64'(ov[0]), 64'd0);
    end

    // Randomized traffic with random back-pressure.
    repeat (3000) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      din = 57'({$urandom, $urandom});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && ov[0]; i++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    chk("final_drain", 64'(ov[0]), 64'd0);
    chk("final_queue_empty", 64'(sbq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
